// File: rtl/d_samp_tx_sched_pkg.sv
// Shared types and default byte patterns for the DDR byte-pair scheduler.
package d_samp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_TRAIN = 2'd1,
      ST_SYNC  = 2'd2,
      ST_DATA  = 2'd3
   } state_e;

   localparam logic [7:0] IDLE_PAT_DEF = 8'h00;
   localparam logic [7:0] TRAIN_A_DEF  = 8'h55;
   localparam logic [7:0] TRAIN_B_DEF  = 8'hAA;
   localparam logic [7:0] SYNC_1_DEF   = 8'hA5;
   localparam logic [7:0] SYNC_2_DEF   = 8'h5A;

endpackage

// File: rtl/d_samp_tx_sched_if.sv
// Upstream valid/ready word stream: data[7:0] feeds data_1, data[15:8] feeds data_2.
interface d_samp_tx_sched_if;
   logic        valid;
   logic [15:0] data;
   logic        last;
   logic        ready;

   modport master (output valid, output data, output last, input ready);
   modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/d_samp_tx_sched_fifo.sv
// Synchronous first-word-fall-through FIFO with an occupancy output.
module d_samp_fifo #(
   parameter int WIDTH = 17,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      level_q, level_d;
   logic             push_ok, pop_ok;

   assign full_o  = (level_q == (AW+1)'(DEPTH));
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign rdata_o = mem_q[rd_ptr_q];
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;

   // Next pointers and occupancy; simultaneous push and pop leave the level unchanged.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
         2'b10:   level_d = level_q + (AW+1)'(1);
         2'b01:   level_d = level_q - (AW+1)'(1);
         default: level_d = level_q;
      endcase
   end

   // Storage array; contents need no reset because the pointers define validity.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
   end

   // Pointer and level registers; reset discards everything buffered.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end
endmodule

// File: rtl/d_samp_tx_sched.sv
// Byte-pair scheduler: buffers upstream words and sequences idle, training, sync and frame data
// onto the two DDR sampler lanes, flagging underruns and frame completion.
module d_samp_tx_sched
   import d_samp_pkg::*;
#(
   parameter int         FIFO_DEPTH = 16,
   parameter int         START_THR  = 4,
   parameter int         TRAIN_LEN  = 64,
   parameter logic [7:0] IDLE_PAT   = IDLE_PAT_DEF,
   parameter logic [7:0] TRAIN_A    = TRAIN_A_DEF,
   parameter logic [7:0] TRAIN_B    = TRAIN_B_DEF,
   parameter logic [7:0] SYNC_1     = SYNC_1_DEF,
   parameter logic [7:0] SYNC_2     = SYNC_2_DEF,
   localparam int        LW         = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable_i,
   input  logic                train_req_i,
   d_samp_tx_sched_if.slave    s_if,
   output logic [7:0]          data_1_o,
   output logic [7:0]          data_2_o,
   output logic                busy_o,
   output logic                underrun_o,
   output logic                frame_done_o,
   output logic [LW-1:0]       fifo_level_o
);
   localparam int CW = $clog2(TRAIN_LEN + 1);

   state_e        state_q;
   logic [7:0]    data_1_q, data_2_q;
   logic          underrun_q, frame_done_q;
   logic          pend_q;
   logic [CW-1:0] cnt_q;
   logic [LW-1:0] last_cnt_q, last_cnt_d;

   logic          fifo_full, fifo_empty;
   logic [16:0]   fifo_rdata;
   logic [LW-1:0] fifo_level;
   logic          push, pop, push_last, pop_last;

   assign s_if.ready = ~fifo_full & ~rst;
   assign push       = s_if.valid & s_if.ready;
   // The head word is consumed in every DATA cycle in which one is available.
   assign pop        = (state_q == ST_DATA) & ~fifo_empty;
   assign push_last  = push & s_if.last;
   assign pop_last   = pop & fifo_rdata[16];

   d_samp_fifo #(
      .WIDTH (17),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .wdata_i ({s_if.last, s_if.data}),
      .pop_i   (pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level)
   );

   // Number of frame-ending words currently buffered, so a short frame can start below threshold.
   always_comb begin
      last_cnt_d = last_cnt_q;
      if (push_last && !pop_last)      last_cnt_d = last_cnt_q + LW'(1);
      else if (pop_last && !push_last) last_cnt_d = last_cnt_q - LW'(1);
   end

   // Last-flag counter register.
   always_ff @(posedge clk) begin
      if (rst) last_cnt_q <= '0;
      else     last_cnt_q <= last_cnt_d;
   end

   // Scheduler FSM with registered lane bytes, strobes, training counter and pending-train flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         data_1_q     <= IDLE_PAT;
         data_2_q     <= IDLE_PAT;
         underrun_q   <= 1'b0;
         frame_done_q <= 1'b0;
         pend_q       <= 1'b0;
         cnt_q        <= '0;
      end else begin
         underrun_q   <= 1'b0;
         frame_done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               data_1_q <= IDLE_PAT;
               data_2_q <= IDLE_PAT;
               if (train_req_i || pend_q) begin
                  state_q <= ST_TRAIN;
                  pend_q  <= 1'b0;
                  cnt_q   <= '0;
               end else if (enable_i &&
                            ((fifo_level >= LW'(START_THR)) || (last_cnt_q != '0))) begin
                  state_q <= ST_SYNC;
               end
            end
            ST_TRAIN: begin
               data_1_q <= TRAIN_A;
               data_2_q <= TRAIN_B;
               cnt_q    <= cnt_q + CW'(1);
               if (cnt_q == CW'(TRAIN_LEN - 1)) state_q <= ST_IDLE;
            end
            ST_SYNC: begin
               data_1_q <= SYNC_1;
               data_2_q <= SYNC_2;
               state_q  <= ST_DATA;
               if (train_req_i) pend_q <= 1'b1;
            end
            ST_DATA: begin
               if (train_req_i) pend_q <= 1'b1;
               if (!fifo_empty) begin
                  data_1_q <= fifo_rdata[7:0];
                  data_2_q <= fifo_rdata[15:8];
                  if (fifo_rdata[16]) begin
                     frame_done_q <= 1'b1;
                     state_q      <= ST_IDLE;
                  end
               end else begin
                  data_1_q   <= IDLE_PAT;
                  data_2_q   <= IDLE_PAT;
                  underrun_q <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign data_1_o     = data_1_q;
   assign data_2_o     = data_2_q;
   assign busy_o       = (state_q != ST_IDLE);
   assign underrun_o   = underrun_q;
   assign frame_done_o = frame_done_q;
   assign fifo_level_o = fifo_level;
endmodule

// File: tb/tb_d_samp_tx_sched.sv
// Directed bench for the DDR byte-pair scheduler.
module tb_d_samp_tx_sched;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b0;
   logic       train_req = 1'b0;
   logic [7:0] data_1, data_2;
   logic       busy, underrun, frame_done;
   logic [4:0] fifo_level;

   int n_chk  = 0;
   int n_pass = 0;

   logic [15:0] mon_log[$];
   logic [15:0] exp_q[$];
   int          mon_under = 0;
   int          mon_fd = 0;
   logic [15:0] mon_fd_word = '0;

   d_samp_tx_sched_if sif ();

   d_samp_tx_sched dut (
      .clk          (clk),
      .rst          (rst),
      .enable_i     (enable),
      .train_req_i  (train_req),
      .s_if         (sif),
      .data_1_o     (data_1),
      .data_2_o     (data_2),
      .busy_o       (busy),
      .underrun_o   (underrun),
      .frame_done_o (frame_done),
      .fifo_level_o (fifo_level)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1);
   end

   // Record every non-idle lane pair and count strobes, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst) begin
         if ({data_2, data_1} != 16'h0000) mon_log.push_back({data_2, data_1});
         if (underrun) mon_under++;
         if (frame_done) begin
            mon_fd++;
            mon_fd_word = {data_2, data_1};
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      if (obs === expv) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
   endtask

   task automatic mon_clear();
      @(posedge clk);
      #1;
      mon_log.delete();
      exp_q.delete();
      mon_under = 0;
      mon_fd = 0;
      mon_fd_word = '0;
   endtask

   task automatic chk_log(input string tag);
      chk({tag, "_len"}, mon_log.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         if (i < mon_log.size()) chk($sformatf("%s_w%0d", tag, i), mon_log[i], exp_q[i]);
   endtask

   task automatic push_word(input logic [15:0] d, input logic l);
      int n = 0;
      @(negedge clk);
      sif.valid = 1'b1;
      sif.data  = d;
      sif.last  = l;
      while (!sif.ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!sif.ready) chk("push_timeout", 32'd0, 32'd1);
      @(posedge clk);
   endtask

   task automatic src_idle();
      @(negedge clk);
      sif.valid = 1'b0;
      sif.last  = 1'b0;
   endtask

   task automatic wait_fd(input string tag, input int want);
      int n = 0;
      while (mon_fd < want && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (mon_fd < want) chk({tag, "_fd_timeout"}, mon_fd, want);
   endtask

   initial begin
      int first, ntr, bad, n;
      sif.valid = 1'b0;
      sif.data  = '0;
      sif.last  = 1'b0;

      // 1: reset and idle
      repeat (3) @(negedge clk);
      chk("rst_ready_low", sif.ready, 1'b0);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      chk("idle_d1", data_1, 8'h00);
      chk("idle_d2", data_2, 8'h00);
      chk("idle_busy", busy, 1'b0);
      chk("idle_ready", sif.ready, 1'b1);
      chk("idle_level", fifo_level, 5'd0);
      chk("idle_strobes", {underrun, frame_done}, 2'b00);

      // 2: one training burst
      first = -1;
      ntr = 0;
      @(negedge clk);
      train_req = 1'b1;
      for (int c = 1; c < 80; c++) begin
         @(negedge clk);
         if (c == 1) train_req = 1'b0;
         if (c == 1) chk("train_busy_early", busy, 1'b1);
         if (data_1 == 8'h55 && data_2 == 8'hAA) begin
            if (first < 0) first = c;
            ntr++;
         end
      end
      chk("train_start", first, 2);
      chk("train_len", ntr, 64);
      chk("train_end_data", {data_2, data_1}, 16'h0000);
      chk("train_end_busy", busy, 1'b0);

      // 3: four-word frame
      mon_clear();
      enable = 1'b1;
      push_word(16'h2211, 1'b0);
      push_word(16'h4433, 1'b0);
      push_word(16'h6655, 1'b0);
      push_word(16'h8877, 1'b1);
      src_idle();
      wait_fd("f4", 1);
      repeat (4) @(negedge clk);
      exp_q = '{16'h5AA5, 16'h2211, 16'h4433, 16'h6655, 16'h8877};
      chk_log("f4");
      chk("f4_fd_cnt", mon_fd, 1);
      chk("f4_fd_word", mon_fd_word, 16'h8877);
      chk("f4_underrun", mon_under, 0);
      chk("f4_busy", busy, 1'b0);

      // 4: six-word frame with a source gap once the FIFO drains
      mon_clear();
      for (int i = 1; i <= 4; i++) push_word(16'h3A00 + 16'(i), 1'b0);
      src_idle();
      n = 0;
      while (!(busy && fifo_level == 5'd0) && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("gap_drained", busy && fifo_level == 5'd0, 1'b1);
      @(negedge clk);
      push_word(16'h3A05, 1'b0);
      push_word(16'h3A06, 1'b1);
      src_idle();
      wait_fd("gap", 1);
      repeat (4) @(negedge clk);
      exp_q = '{16'h5AA5, 16'h3A01, 16'h3A02, 16'h3A03, 16'h3A04, 16'h3A05, 16'h3A06};
      chk_log("gap");
      chk("gap_underrun", mon_under, 3);
      chk("gap_fd_cnt", mon_fd, 1);
      chk("gap_fd_word", mon_fd_word, 16'h3A06);

      // 5: fill to full while start is gated, then release
      mon_clear();
      enable = 1'b0;
      for (int i = 1; i <= 16; i++) push_word(16'hB0C0 + 16'h0101 * 16'(i), 1'b0);
      @(negedge clk);
      sif.valid = 1'b1;
      sif.data  = 16'hB0C0 + 16'h0101 * 16'd17;
      sif.last  = 1'b1;
      chk("full_level", fifo_level, 5'd16);
      chk("full_ready", sif.ready, 1'b0);
      bad = 0;
      repeat (4) begin
         @(negedge clk);
         if (sif.ready || fifo_level != 5'd16 || busy) bad++;
      end
      chk("full_hold", bad, 0);
      enable = 1'b1;
      n = 0;
      while (!sif.ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("full_release", sif.ready, 1'b1);
      @(posedge clk);
      src_idle();
      wait_fd("full", 1);
      repeat (4) @(negedge clk);
      exp_q.push_back(16'h5AA5);
      for (int i = 1; i <= 17; i++) exp_q.push_back(16'hB0C0 + 16'h0101 * 16'(i));
      chk_log("full");
      chk("full_underrun", mon_under, 0);
      chk("full_fd_word", mon_fd_word, 16'hC1D1);
      chk("full_empty_after", fifo_level, 5'd0);

      // 6: train request mid-frame, then reset during training
      mon_clear();
      push_word(16'h1357, 1'b0);
      push_word(16'h2468, 1'b0);
      push_word(16'h369C, 1'b0);
      push_word(16'h48AD, 1'b1);
      src_idle();
      n = 0;
      while (mon_log.size() < 2 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("mid_in_data", busy, 1'b1);
      train_req = 1'b1;
      @(negedge clk);
      train_req = 1'b0;
      n = 0;
      while (mon_log.size() < 15 && n < 100) begin
         @(negedge clk);
         n++;
      end
      exp_q = '{16'h5AA5, 16'h1357, 16'h2468, 16'h369C, 16'h48AD};
      chk("mid_log_len", mon_log.size() >= 15, 1'b1);
      for (int i = 0; i < 5; i++)
         if (i < mon_log.size()) chk($sformatf("mid_w%0d", i), mon_log[i], exp_q[i]);
      bad = 0;
      for (int i = 5; i < mon_log.size(); i++) if (mon_log[i] != 16'hAA55) bad++;
      chk("mid_train_follows", bad, 0);
      chk("mid_fd_cnt", mon_fd, 1);
      chk("mid_train_busy", busy, 1'b1);
      push_word(16'h7777, 1'b0);
      src_idle();
      chk("mid_level_one", fifo_level, 5'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_data", {data_2, data_1}, 16'h0000);
      chk("rst_mid_level", fifo_level, 5'd0);
      chk("rst_mid_busy", busy, 1'b0);
      chk("rst_mid_ready", sif.ready, 1'b0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("post_rst_idle", {busy, data_2, data_1}, 17'h0);
      chk("post_rst_ready", sif.ready, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
